// File: rtl/dwc_weight_streamer.sv
// Depthwise weight streamer: fetches one 3x3 tap group from weight SRAM and
// emits it as nine contiguous beats into the depthwise PU tap registers.
module dwc_weight_streamer #(
    parameter int UNIT_NUM = 16,
    parameter int DATA_W   = 8,
    parameter int TAP_NUM  = 9,
    parameter int ADDR_W   = 12,
    parameter int GRP_W    = 8,
    parameter int RD_LAT   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic [GRP_W-1:0]             grp_idx_i,
    input  logic                         pu_busy_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         mem_rd_en_o,
    output logic [ADDR_W-1:0]            mem_rd_addr_o,
    input  logic [UNIT_NUM*DATA_W-1:0]   mem_rd_data_i,
    output logic                         w_valid_o,
    output logic [3:0]                   w_idx_o,
    output logic [UNIT_NUM*DATA_W-1:0]   w_data_o
);

    localparam int WORD_W = UNIT_NUM * DATA_W;
    localparam int SUM_W  = ADDR_W + GRP_W + 4;
    localparam logic [3:0] LAST_TAP  = 4'(TAP_NUM - 1);
    localparam logic [2:0] DRAIN_END = 3'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   grp_addr_q, grp_addr_d;
    logic [3:0]          tap_q, tap_d;
    logic [2:0]          drain_q, drain_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

    // Tag pipeline that travels alongside the SRAM read latency.
    logic                tag_valid_q [RD_LAT];
    logic [3:0]          tag_tap_q   [RD_LAT];

    logic                w_valid_q;
    logic [3:0]          w_idx_q;
    logic [WORD_W-1:0]   w_data_q;

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        grp_addr_d = grp_addr_q;
        tap_d      = tap_q;
        drain_d    = drain_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    grp_addr_d = ADDR_W'(SUM_W'(base_addr_i)
                                 + SUM_W'(grp_idx_i) * SUM_W'(TAP_NUM));
                    tap_d      = 4'd0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!pu_busy_i) begin
                    state_d   = S_ISSUE;
                    tap_d     = 4'd0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = grp_addr_q;
                end
            end
            S_ISSUE: begin
                // tap_q names the read currently on the SRAM port.
                if (tap_q == LAST_TAP) begin
                    state_d = S_DRAIN;
                    drain_d = 3'd0;
                end else begin
                    tap_d     = tap_q + 4'd1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = grp_addr_q + ADDR_W'(tap_q + 4'd1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_END) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grp_addr_q <= '0;
            tap_q      <= '0;
            drain_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            grp_addr_q <= grp_addr_d;
            tap_q      <= tap_d;
            drain_q    <= drain_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // NOTE: only the tag valid bits are reset; tap indices are don't-care
    // whenever their valid bit is low because the output stage gates them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_valid_q[i] <= 1'b0;
            end
        end else begin
            tag_valid_q[0] <= rd_en_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_tap_q[0] <= tap_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_tap_q[i] <= tag_tap_q[i-1];
        end
    end

    // Output stage: the tag reaching the last stage lines up with read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_valid_q <= 1'b0;
            w_idx_q   <= '0;
            w_data_q  <= '0;
        end else if (tag_valid_q[RD_LAT-1]) begin
            w_valid_q <= 1'b1;
            w_idx_q   <= tag_tap_q[RD_LAT-1];
            w_data_q  <= mem_rd_data_i;
        end else begin
            w_valid_q <= 1'b0;
            w_idx_q   <= '0;
            w_data_q  <= '0;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign mem_rd_en_o   = rd_en_q;
    assign mem_rd_addr_o = rd_addr_q;
    assign w_valid_o     = w_valid_q;
    assign w_idx_o       = w_idx_q;
    assign w_data_o      = w_data_q;

endmodule

// File: tb/tb_dwc_weight_streamer.sv
// Bench for dwc_weight_streamer: three instances (RD_LAT 1..3) share stimulus;
// expectations come from a cycle-timeline model plus a PU tap-register model.
module tb_dwc_weight_streamer;

    localparam int W  = 128;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [11:0]   base_addr;
    logic [7:0]    grp_idx;
    logic          pu_busy;

    logic          busy    [NI];
    logic          done    [NI];
    logic          rd_en   [NI];
    logic [11:0]   rd_addr [NI];
    logic [W-1:0]  rd_data [NI];
    logic          w_valid [NI];
    logic [3:0]    w_idx   [NI];
    logic [W-1:0]  w_data  [NI];

    logic [11:0]   apipe  [NI][4];
    logic [W-1:0]  pu_tap [NI][9];

    int            total = 0;
    int            bad   = 0;
    logic [11:0]   last_addr;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] word(input logic [11:0] a);
        return {16{a[7:0]}};
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_dut
        dwc_weight_streamer #(.RD_LAT(k + 1)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .start_i       (start),
            .base_addr_i   (base_addr),
            .grp_idx_i     (grp_idx),
            .pu_busy_i     (pu_busy),
            .busy_o        (busy[k]),
            .done_o        (done[k]),
            .mem_rd_en_o   (rd_en[k]),
            .mem_rd_addr_o (rd_addr[k]),
            .mem_rd_data_i (rd_data[k]),
            .w_valid_o     (w_valid[k]),
            .w_idx_o       (w_idx[k]),
            .w_data_o      (w_data[k])
        );
        // SRAM with latency k+1: the address of cycle c is answered in c+k+1.
        assign rd_data[k] = word(apipe[k][k]);
    end

    // SRAM address pipes and the depthwise PU tap registers.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            apipe[k][0] <= rd_addr[k];
            for (int i = 1; i < 4; i++) apipe[k][i] <= apipe[k][i-1];
            if (w_valid[k] && w_idx[k] < 4'd9) pu_tap[k][int'(w_idx[k])] <= w_data[k];
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One group request; hold = cycles pu_busy stays high after start,
    // stray = extra start pulses mid-stream, abort = reset at ISSUE tap 4.
    task automatic stream(input int base, input int grp, input int hold,
                          input bit stray, input bit abort);
        int          ga;
        int          abort_at;
        int          lat;
        int          ti;
        bit          ab;
        bit          e_rd;
        bit          e_bt;
        logic [11:0] e_addr;
        ga       = (base + grp * 9) % 4096;
        abort_at = hold + 6;
        for (int n = 0; n <= hold + 15; n++) begin
            @(negedge clk);
            e_addr = last_addr;
            for (int k = 0; k < NI; k++) begin
                lat    = k + 1;
                ab     = abort && (n > abort_at);
                e_rd   = !ab && (n >= hold + 2) && (n <= hold + 10);
                e_bt   = !ab && (n >= hold + 3 + lat) && (n <= hold + 11 + lat);
                ti     = n - hold - 3 - lat;
                e_addr = ab ? 12'h000 : (e_rd ? 12'(ga + n - hold - 2) : last_addr);
                check($sformatf("busy k%0d n%0d", k, n), W'(busy[k]),
                      W'(!ab && n >= 1 && n <= hold + 12 + lat));
                check($sformatf("done k%0d n%0d", k, n), W'(done[k]),
                      W'(!ab && n == hold + 12 + lat));
                check($sformatf("rd_en k%0d n%0d", k, n), W'(rd_en[k]), W'(e_rd));
                check($sformatf("rd_addr k%0d n%0d", k, n), W'(rd_addr[k]), W'(e_addr));
                check($sformatf("w_valid k%0d n%0d", k, n), W'(w_valid[k]), W'(e_bt));
                check($sformatf("w_idx k%0d n%0d", k, n), W'(w_idx[k]),
                      e_bt ? W'(ti) : W'(0));
                check($sformatf("w_data k%0d n%0d", k, n), w_data[k],
                      e_bt ? word(12'(ga + ti)) : W'(0));
            end
            last_addr = e_addr;
            start     = (n == 0) || (stray && (n == 3 || n == 7));
            base_addr = (n == 0) ? 12'(base) : 12'($urandom);
            grp_idx   = (n == 0) ? 8'(grp) : 8'($urandom);
            if (n >= 1 && n <= hold) pu_busy = 1'b1;
            else if (n == hold + 1)  pu_busy = 1'b0;
            else                     pu_busy = 1'($urandom);
            rst_n = !(abort && n == abort_at);
        end
        start = 1'b0;
        if (!abort) begin
            for (int k = 0; k < NI; k++) begin
                for (int t = 0; t < 9; t++) begin
                    check($sformatf("pu_tap k%0d t%0d", k, t), pu_tap[k][t], word(12'(ga + t)));
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        grp_idx   = '0;
        pu_busy   = 1'b0;
        last_addr = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst busy k%0d", k), W'(busy[k]), W'(0));
            check($sformatf("rst done k%0d", k), W'(done[k]), W'(0));
            check($sformatf("rst rd_en k%0d", k), W'(rd_en[k]), W'(0));
            check($sformatf("rst rd_addr k%0d", k), W'(rd_addr[k]), W'(0));
            check($sformatf("rst w_valid k%0d", k), W'(w_valid[k]), W'(0));
            check($sformatf("rst w_idx k%0d", k), W'(w_idx[k]), W'(0));
            check($sformatf("rst w_data k%0d", k), w_data[k], W'(0));
        end
        rst_n = 1'b1;

        stream(32'h100, 2, 0, 1'b0, 1'b0);
        stream(32'h100, 2, 20, 1'b0, 1'b0);
        stream(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)), 1, 1'b1, 1'b0);
        stream(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
        stream(32'hFFC, 0, 0, 1'b0, 1'b0);
        stream(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)), 2, 1'b0, 1'b1);
        stream(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            stream(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 4)), 1'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
